// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store unit front end for a single-port data-memory bus.
// Takes one core load/store at a time, rejects illegal or misaligned accesses
// without touching the bus, runs a request/grant then response handshake, and
// hands the raw word plus offset/size to the downstream load extender.
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] ReadData,
  output logic [1:0]  offset,
  output logic [2:0]  MemSize,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Counter value of the last cycle an access may spend in REQ+WAIT.
  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_SIZE     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  logic [1:0]  state;
  logic [7:0]  cycle_cnt;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        size_illegal;
  logic        misaligned;
  logic        timed_out;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Classify the incoming request; size legality is judged before alignment.
  always_comb begin
    size_illegal = 1'b0;
    case (req_size)
      3'b011, 3'b110, 3'b111: size_illegal = 1'b1;
      3'b100, 3'b101:         size_illegal = req_we;
      default:                size_illegal = 1'b0;
    endcase
    misaligned = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Byte enables and lane-replicated store data from the captured request.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = 32'h0;
    if (we_q) begin
      case (size_q[1:0])
        2'b00: begin
          be_calc    = 4'b0001 << addr_q[1:0];
          wdata_calc = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be_calc    = 4'b0011 << {addr_q[1], 1'b0};
          wdata_calc = {2{wdata_q[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = wdata_q;
        end
      endcase
    end
  end

  // The bus is only driven while the request phase is open.
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? be_calc : 4'b0000;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? wdata_calc : 32'h0;

  assign done      = (state == DONE);
  assign stall     = req_valid & ~done;
  assign timed_out = (cycle_cnt >= LAST_CYCLE);

  // Main sequencer: capture, handshake, completion and fault bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cycle_cnt   <= 8'd0;
      we_q        <= 1'b0;
      size_q      <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      ReadData    <= 32'h0;
      offset      <= 2'b00;
      MemSize     <= 3'b000;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            offset    <= req_addr[1:0];
            MemSize   <= req_size;
            cycle_cnt <= 8'd0;
            if (size_illegal) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_SIZE;
              state       <= DONE;
            end else if (misaligned) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
              state       <= DONE;
            end else begin
              fault       <= 1'b0;
              fault_cause <= CAUSE_NONE;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          cycle_cnt <= cycle_cnt + 8'd1;
          if (mem_gnt) begin
            state <= WAIT;
          end else if (timed_out) begin
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            state       <= DONE;
          end
        end
        WAIT: begin
          cycle_cnt <= cycle_cnt + 8'd1;
          if (mem_rvalid) begin
            if (!we_q) begin
              ReadData <= mem_rdata;
            end
            state <= DONE;
          end else if (timed_out) begin
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles in REQ+WAIT before a bus-timeout fault (1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  core presents a load/store; held stable until done.
REQ-005 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_size  input  3  funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port stall  output  1  core must hold PC/request.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ReadData  output  32  raw memory word captured for the load extender.
REQ-012 SHALL have port offset  output  2  captured req_addr[1:0].
REQ-013 SHALL have port MemSize  output  3  captured req_size.
REQ-014 SHALL have port fault  output  1  access faulted; valid with done.
REQ-015 SHALL have port fault_cause  output  2  01 misaligned, 10 illegal size, 11 bus timeout, 00 none.
REQ-016 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_be out 4, mem_wdata out 32, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32: data-memory bus.

Function
REQ-017 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: on req_valid, SHALL capture we/size/addr/wdata; legal and aligned -> REQ; otherwise -> DONE with fault.
REQ-019 Illegal size SHALL be 011, 110, 111 for any access; 100/101 for stores (cause 10, takes precedence over misalignment).
REQ-020 Misaligned SHALL be H/HU with addr[0]=1, W with addr[1:0]!=00 (cause 01); faulted accesses SHALL never assert mem_req.
REQ-021 stall SHALL equal req_valid AND NOT done (combinational); stall=0 in DONE.
REQ-022 REQ: mem_req=1 with mem_addr={addr[31:2],2'b00} and mem_we/mem_be/mem_wdata stable until mem_gnt=1; on gnt -> WAIT next cycle.
REQ-023 mem_be SHALL be 1111 for loads and SW, 0001<<addr[1:0] for SB, 0011<<(2*addr[1]) for SH.
REQ-024 mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, wdata for SW, 0 for loads.
REQ-025 WAIT: mem_rvalid=1 SHALL complete the access (loads and stores); loads capture mem_rdata into ReadData; -> DONE. mem_rvalid outside WAIT SHALL be ignored.
REQ-026 An 8-bit counter SHALL clear on IDLE->REQ and increment each cycle in REQ/WAIT; reaching TIMEOUT without completion -> DONE with cause 11, mem_req deasserted.
REQ-027 DONE: done=1 for exactly one cycle, then unconditionally IDLE; no new request is accepted in DONE.
REQ-028 ReadData, offset, MemSize, fault, fault_cause SHALL be registered and hold until the next capture; ReadData unchanged on stores and faults.
REQ-029 Minimum latency SHALL be 3 cycles from req_valid in IDLE to done (gnt in REQ's first cycle, rvalid in WAIT's first cycle).

Reset
REQ-030 On rst=1 at a clock edge, state SHALL become IDLE; counter, done, fault, fault_cause, mem_req, mem_we, mem_be, ReadData, offset, MemSize SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon the access without done; mem_req low from the cycle after the reset edge; late mem_rvalid ignored.

Verification
REQ-032 LBU addr 0x1003, gnt at once, rvalid next cycle rdata 0xAABBCCDD -> done on cycle 3, ReadData 0xAABBCCDD, offset 3, MemSize 100, mem_be 1111, fault 0.
REQ-033 SH addr 0x2002 wdata 0x0000BEEF -> mem_addr 0x2000, mem_be 1100, mem_wdata 0xBEEFBEEF, mem_we 1; gnt delayed 4 cycles keeps all stable.
REQ-034 LW addr 0x3001 -> done next cycle, fault 1, cause 01, mem_req never asserted; SB size 100 -> cause 10.
REQ-035 TIMEOUT=8, gnt never given -> mem_req high 8 cycles, then done with cause 11, mem_req 0.
REQ-036 rst asserted in WAIT, rvalid arrives after -> no done, IDLE, outputs 0; next LB completes normally.
